pc_unit_ras: RTL and testbench

- Parametrised next-generation program counter for the tiny core's fetch stage.
- Adds configurable address width and reset vector, plus PC-relative branches.
- Adds hardware CALL/RET through an internal return-address stack (RAS) with full/empty status and sticky error flags.
- Sits between the Control Unit (redirect requests) and instruction memory (mem_ready stall).

---
 rtl/pc_pkg.sv | 31 +++
 rtl/return_stack.sv | 59 +++++
 rtl/pc_unit_ras.sv | 103 ++++++++++
 tb/tb_pc_unit_ras.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Holds the default widths and reset vector, the PC word type, and the
// next-PC source select encoding (also useful as a debug probe in benches).
package pc_pkg;

    localparam int              PC_W_DEF      = 16;
    localparam int              OFF_W_DEF     = 8;
    localparam logic [15:0]     RESET_VEC_DEF = 16'h0000;

    typedef logic [PC_W_DEF-1:0] pc_t;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        PC_SEL_RET,
        PC_SEL_CALL,
        PC_SEL_JUMP,
        PC_SEL_REL,
        PC_SEL_SEQ
    } pc_sel_e;

    // Fixed priority: ret > call > jump > rel > sequential.
    function automatic pc_sel_e pc_select(input logic ret, input logic call,
                                          input logic jump, input logic rel);
        if (ret)       return PC_SEL_RET;
        else if (call) return PC_SEL_CALL;
        else if (jump) return PC_SEL_JUMP;
        else if (rel)  return PC_SEL_REL;
        else           return PC_SEL_SEQ;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack.
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears count only)
//   push, pop       push_data onto / remove top of the stack
//   push_data       address to push
//   top             current top entry (undefined content when empty)
//   count           number of valid entries
//   full, empty     count == DEPTH / count == 0
// Push when full and pop when empty are silently ignored; the parent owns
// the error reporting. Pop wins if both are requested in the same cycle.
module return_stack #(
    parameter int  DEPTH = 4,
    parameter int  W     = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic [W-1:0]     top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    import pc_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic             do_pop;
    logic             do_push;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic [CNT_W-1:0] count_m1;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && !full && !do_pop;
    assign count_m1 = count - CNT_W'(1);

    // The count doubles as the write pointer; the top sits one below it.
    assign wr_idx = count[PTR_W-1:0];
    assign rd_idx = count_m1[PTR_W-1:0];
    assign top    = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst)         count <= '0;
        else if (do_pop)  count <= count_m1;
        else if (do_push) count <= count + CNT_W'(1);
    end

    // Storage is deliberately not reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with relative branches and a hardware
// return-address stack for CALL/RET.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   mem_ready         fetch accepted; PC and stack may advance
//   jump_en/jump_addr absolute jump request and target (also call target)
//   rel_en/rel_offset relative branch, signed offset added to pc_current
//   call_en, ret_en   call (push pc+1, go to jump_addr) / return (pop)
//   err_clr           clears sticky error flags (ignores mem_ready)
//   pc_current        registered PC
//   ras_count         registered stack occupancy; ras_full/ras_empty decode it
//   err_overflow      sticky: call while stack full
//   err_underflow     sticky: ret while stack empty
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              OFF_W     = OFF_W_DEF,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    localparam int             CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic              jump_en,
    input  logic [PC_W-1:0]   jump_addr,
    input  logic              rel_en,
    input  logic [OFF_W-1:0]  rel_offset,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              err_clr,
    output logic [PC_W-1:0]   pc_current,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              err_overflow,
    output logic              err_underflow
);

    pc_sel_e          sel;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  ras_top;
    logic             ras_push;
    logic             ras_pop;
    logic             ovf_set;
    logic             unf_set;

    assign sel     = pc_select(ret_en, call_en, jump_en, rel_en);
    assign pc_inc  = pc_current + PC_W'(1);
    assign off_ext = PC_W'($signed(rel_offset));

    // Only the winning request touches the stack, and only on an accepted fetch.
    assign ras_push = mem_ready && (sel == PC_SEL_CALL);
    assign ras_pop  = mem_ready && (sel == PC_SEL_RET);
    assign ovf_set  = ras_push && ras_full;
    assign unf_set  = ras_pop && ras_empty;

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        pc_next = pc_inc;
        unique case (sel)
            PC_SEL_RET:  pc_next = ras_empty ? pc_inc : ras_top;
            PC_SEL_CALL: pc_next = jump_addr;
            PC_SEL_JUMP: pc_next = jump_addr;
            PC_SEL_REL:  pc_next = pc_current + off_ext;
            default:     pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)           pc_current <= RESET_VEC;
        else if (mem_ready) pc_current <= pc_next;
    end

    // Set dominates clear so a fresh error is never lost to a stale clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= ovf_set || (err_overflow  && !err_clr);
            err_underflow <= unf_set || (err_underflow && !err_clr);
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: stimulus pushes hand-computed expected
// state per cycle, a monitor pops and compares after each rising edge.
module tb_pc_unit_ras;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ready = 1'b0, jump_en = 1'b0, rel_en = 1'b0;
    logic        call_en = 1'b0, ret_en = 1'b0, err_clr = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [7:0]  rel_offset = '0;

    logic [15:0] pc, pc2;
    logic [2:0]  cnt, cnt2;
    logic        full, empty, ovf, unf, full2, empty2, ovf2, unf2;

    typedef struct {
        pc_t        pc;
        int         cnt;
        bit         ovf;
        bit         unf;
        bit         chk2;
        pc_t        pc2;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_unit_ras #(.PC_W(16), .OFF_W(8), .RAS_DEPTH(4), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .jump_en(jump_en),
        .jump_addr(jump_addr), .rel_en(rel_en), .rel_offset(rel_offset),
        .call_en(call_en), .ret_en(ret_en), .err_clr(err_clr),
        .pc_current(pc), .ras_count(cnt), .ras_full(full), .ras_empty(empty),
        .err_overflow(ovf), .err_underflow(unf)
    );

    pc_unit_ras #(.PC_W(16), .OFF_W(8), .RAS_DEPTH(4), .RESET_VEC(16'h0100)) dut_rv (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .jump_en(jump_en),
        .jump_addr(jump_addr), .rel_en(rel_en), .rel_offset(rel_offset),
        .call_en(call_en), .ret_en(ret_en), .err_clr(err_clr),
        .pc_current(pc2), .ras_count(cnt2), .ras_full(full2), .ras_empty(empty2),
        .err_overflow(ovf2), .err_underflow(unf2)
    );

    task automatic chk(input string name, input string tag, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, name, act, req);
        end
    endtask

    // Monitor: every edge with a pending expectation is one DUT response.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc",    e.tag, int'(pc),    int'(e.pc));
            chk("count", e.tag, int'(cnt),   e.cnt);
            chk("full",  e.tag, int'(full),  int'(e.cnt == 4));
            chk("empty", e.tag, int'(empty), int'(e.cnt == 0));
            chk("ovf",   e.tag, int'(ovf),   int'(e.ovf));
            chk("unf",   e.tag, int'(unf),   int'(e.unf));
            if (e.chk2) chk("pc_rv", e.tag, int'(pc2), int'(e.pc2));
        end
    end

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic cyc(input string tag, input bit r, input bit mr,
                       input bit rt, input bit cl, input bit jp, input bit rl,
                       input bit clr, input logic [15:0] addr, input logic [7:0] off,
                       input logic [15:0] epc, input int ecnt, input bit eovf,
                       input bit eunf, input bit c2 = 1'b0,
                       input logic [15:0] epc2 = 16'h0);
        exp_t e;
        @(negedge clk);
        rst = r; mem_ready = mr; ret_en = rt; call_en = cl; jump_en = jp;
        rel_en = rl; err_clr = clr; jump_addr = addr; rel_offset = off;
        e.pc = epc; e.cnt = ecnt; e.ovf = eovf; e.unf = eunf;
        e.chk2 = c2; e.pc2 = epc2; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        //   tag        rst mr rt cl jp rl clr addr      off    pc       cnt ovf unf
        cyc("reset0",   0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0100);
        cyc("reset1",   0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0100);
        cyc("seq1",     1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0001, 0, 0, 0, 1, 16'h0101);
        cyc("seq2",     1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0002, 0, 0, 0, 1, 16'h0102);
        cyc("seq3",     1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0003, 0, 0, 0, 1, 16'h0103);
        cyc("stall1",   1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0003, 0, 0, 0, 1, 16'h0103);
        cyc("stall2",   1, 0, 0, 0, 1, 0, 0, 16'h0777, 8'h00, 16'h0003, 0, 0, 0, 1, 16'h0103);
        // Relative branches and wrap in both directions
        cyc("jmp10",    1, 1, 0, 0, 1, 0, 0, 16'h0010, 8'h00, 16'h0010, 0, 0, 0);
        cyc("rel_m8",   1, 1, 0, 0, 0, 1, 0, 16'h0000, 8'hF8, 16'h0008, 0, 0, 0);
        cyc("jmpFFFF",  1, 1, 0, 0, 1, 0, 0, 16'hFFFF, 8'h00, 16'hFFFF, 0, 0, 0);
        cyc("wrap_up",  1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0);
        cyc("seq_a",    1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0001, 0, 0, 0);
        cyc("seq_b",    1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0002, 0, 0, 0);
        cyc("rel_wrap", 1, 1, 0, 0, 0, 1, 0, 16'h0000, 8'hFC, 16'hFFFE, 0, 0, 0);
        cyc("rel_pos",  1, 1, 0, 0, 0, 1, 0, 16'h0000, 8'h7F, 16'h007D, 0, 0, 0);
        // Nested call/return
        cyc("jmp20",    1, 1, 0, 0, 1, 0, 0, 16'h0020, 8'h00, 16'h0020, 0, 0, 0);
        cyc("call100",  1, 1, 0, 1, 0, 0, 0, 16'h0100, 8'h00, 16'h0100, 1, 0, 0);
        cyc("call200",  1, 1, 0, 1, 0, 0, 0, 16'h0200, 8'h00, 16'h0200, 2, 0, 0);
        cyc("ret_a",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0101, 1, 0, 0);
        cyc("ret_b",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0021, 0, 0, 0);
        // Overflow / underflow
        cyc("jmp0",     1, 1, 0, 0, 1, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0);
        cyc("callx1",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 1, 0, 0);
        cyc("callx2",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 2, 0, 0);
        cyc("callx3",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 3, 0, 0);
        cyc("callx4",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 4, 0, 0);
        cyc("callx5",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 4, 1, 0);
        cyc("retx1",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0011, 3, 1, 0);
        cyc("retx2",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0011, 2, 1, 0);
        cyc("retx3",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0011, 1, 1, 0);
        cyc("retx4",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0001, 0, 1, 0);
        cyc("retx5",    1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0002, 0, 1, 1);
        // New underflow with clear: underflow stays, overflow (no set) clears
        cyc("unf_clr",  1, 1, 1, 0, 0, 0, 1, 16'h0000, 8'h00, 16'h0003, 0, 0, 1);
        // Clear works even while stalled
        cyc("clr_stl",  1, 0, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 16'h0003, 0, 0, 0);
        // Priority: one entry 0x0055 on the stack
        cyc("jmp54",    1, 1, 0, 0, 1, 0, 0, 16'h0054, 8'h00, 16'h0054, 0, 0, 0);
        cyc("call300",  1, 1, 0, 1, 0, 0, 0, 16'h0300, 8'h00, 16'h0300, 1, 0, 0);
        cyc("prio_stl", 1, 0, 1, 1, 1, 1, 0, 16'h0400, 8'h10, 16'h0300, 1, 0, 0);
        cyc("prio",     1, 1, 1, 1, 1, 1, 0, 16'h0400, 8'h10, 16'h0055, 0, 0, 0);
        cyc("post_pr",  1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0056, 0, 0, 0);
        // Reset in the middle of activity, while stalled
        cyc("callr1",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 1, 0, 0);
        cyc("callr2",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 2, 0, 0);
        cyc("callr3",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 3, 0, 0);
        cyc("callr4",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 4, 0, 0);
        cyc("callr5",   1, 1, 0, 1, 0, 0, 0, 16'h0010, 8'h00, 16'h0010, 4, 1, 0);
        cyc("retr",     1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0011, 3, 1, 0);
        cyc("rst_mid",  0, 0, 1, 1, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0100);
        cyc("unf_rst",  1, 1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0001, 0, 0, 1, 1, 16'h0101);

        @(negedge clk);
        mem_ready = 1'b0; ret_en = 1'b0; call_en = 1'b0; jump_en = 1'b0;
        rel_en = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
